// File: rtl/vpu_exec_pkg.sv
// Shared types for the vector execution path: ALU op codes, element-size
// encoding and the sequencer state enum.
package vpu_exec_pkg;

  localparam int unsigned ELEN_W = 2;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'd0,
    ALU_SUB     = 3'd1,
    ALU_OR      = 3'd2,
    ALU_AND     = 3'd3,
    ALU_NOT     = 3'd4,
    ALU_XOR     = 3'd5,
    ALU_MUL     = 3'd6,
    ALU_ILLEGAL = 3'd7
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Element size in bytes for an element-size code (0:8b, 1:16b, 2:32b).
  function automatic logic [3:0] elen_bytes(input logic [ELEN_W-1:0] elen);
    return 4'(1) << elen;
  endfunction

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// Instruction, result and external-ALU signals of the vector ALU sequencer.
interface vec_alu_sequencer_if #(
  parameter int unsigned VLEN   = 256,
  parameter int unsigned LENGTH = 32
);

  localparam int unsigned ELEN_W = vpu_exec_pkg::ELEN_W;
  localparam int unsigned VL_W   = $clog2(VLEN / 8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [ELEN_W-1:0] in_elen;
  logic [VL_W-1:0]   in_vl;
  logic [VLEN-1:0]   in_vs1;
  logic [VLEN-1:0]   in_vs2;

  logic [2:0]        alu_mode;
  logic [ELEN_W-1:0] alu_elen;
  logic [LENGTH-1:0] alu_op1;
  logic [LENGTH-1:0] alu_op2;
  logic              alu_carry_in;
  logic [LENGTH-1:0] alu_out;
  logic              alu_carry;

  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   out_data;
  logic [VLEN/8-1:0] out_byte_en;
  logic              out_err;

  // Sequencer side.
  modport slave (
    input  in_valid, in_mode, in_elen, in_vl, in_vs1, in_vs2,
    input  alu_out, alu_carry, out_ready,
    output in_ready,
    output alu_mode, alu_elen, alu_op1, alu_op2, alu_carry_in,
    output out_valid, out_data, out_byte_en, out_err
  );

  // Issuing / consuming side, which also hosts the ALU.
  modport master (
    output in_valid, in_mode, in_elen, in_vl, in_vs1, in_vs2,
    output alu_out, alu_carry, out_ready,
    input  in_ready,
    input  alu_mode, alu_elen, alu_op1, alu_op2, alu_carry_in,
    input  out_valid, out_data, out_byte_en, out_err
  );

endinterface

// File: rtl/vec_alu_sequencer.sv
// Streams one vector instruction through an external LENGTH-bit ALU, one
// beat per cycle, and returns the assembled, byte-masked result vector.
module vec_alu_sequencer
  import vpu_exec_pkg::*;
#(
  parameter int unsigned VLEN       = 256,
  parameter int unsigned LENGTH     = 32,
  parameter int unsigned SUB_LENGTH = 8
) (
  input logic                clk,
  input logic                rst,
  vec_alu_sequencer_if.slave bus
);

  localparam int unsigned NBYTES = VLEN / 8;
  localparam int unsigned NBEATS = VLEN / LENGTH;
  localparam int unsigned BPB    = LENGTH / 8;
  localparam int unsigned VL_W   = $clog2(NBYTES) + 1;
  localparam int unsigned CNT_W  = VL_W + 1;
  localparam int unsigned BEAT_W = $clog2(NBEATS + 1);

  seq_state_e        state;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] last_q;
  logic [VLEN-1:0]   vs1_q;
  logic [VLEN-1:0]   vs2_q;
  logic [NBYTES-1:0] mask_q;
  logic [VLEN-1:0]   buffer_q;

  logic [VL_W-1:0]   max_el_c;
  logic [VL_W-1:0]   vl_eff_c;
  logic [VL_W-1:0]   nb_c;
  logic [CNT_W-1:0]  nbeats_c;
  logic [NBYTES-1:0] mask_c;
  logic [BEAT_W-1:0] beat_nxt_c;
  logic [LENGTH-1:0] op1_nxt_c;
  logic [LENGTH-1:0] op2_nxt_c;
  logic [VLEN-1:0]   merged_c;
  logic              unused_c;

  // Lane width and ALU carry-out only matter to the external ALU.
  assign unused_c = ^{bus.alu_carry, 32'(SUB_LENGTH)};

  // Element clamp, bytes written and beat count for the offered instruction.
  assign max_el_c   = VL_W'(NBYTES) >> bus.in_elen;
  assign vl_eff_c   = (bus.in_vl < max_el_c) ? bus.in_vl : max_el_c;
  assign nb_c       = VL_W'(vl_eff_c * VL_W'(elen_bytes(bus.in_elen)));
  assign nbeats_c   = CNT_W'((CNT_W'(nb_c) + CNT_W'(BPB - 1)) / CNT_W'(BPB));
  assign beat_nxt_c = beat_q + BEAT_W'(1);

  always_comb begin
    mask_c = '0;
    for (int k = 0; k < NBYTES; k++) begin
      mask_c[k] = (VL_W'(k) < nb_c);
    end
  end

  // Operand slices for the beat that follows the current one.
  always_comb begin
    op1_nxt_c = '0;
    op2_nxt_c = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat_nxt_c == BEAT_W'(i)) begin
        op1_nxt_c = vs1_q[i*LENGTH +: LENGTH];
        op2_nxt_c = vs2_q[i*LENGTH +: LENGTH];
      end
    end
  end

  // Buffer with this beat's ALU result merged in and inactive bytes zeroed.
  always_comb begin
    merged_c = buffer_q;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat_q == BEAT_W'(i)) begin
        merged_c[i*LENGTH +: LENGTH] = bus.alu_out;
      end
    end
    for (int k = 0; k < NBYTES; k++) begin
      if (!mask_q[k]) begin
        merged_c[k*8 +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      beat_q           <= '0;
      last_q           <= '0;
      vs1_q            <= '0;
      vs2_q            <= '0;
      mask_q           <= '0;
      buffer_q         <= '0;
      bus.in_ready     <= 1'b1;
      bus.alu_mode     <= '0;
      bus.alu_elen     <= '0;
      bus.alu_op1      <= '0;
      bus.alu_op2      <= '0;
      bus.alu_carry_in <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_byte_en  <= '0;
      bus.out_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            vs1_q           <= bus.in_vs1;
            vs2_q           <= bus.in_vs2;
            mask_q          <= mask_c;
            buffer_q        <= '0;
            beat_q          <= '0;
            last_q          <= BEAT_W'(nbeats_c - CNT_W'(1));
            bus.in_ready    <= 1'b0;
            bus.out_data    <= '0;
            bus.out_byte_en <= '0;
            bus.out_err     <= 1'b0;
            if ((bus.in_mode == ALU_ILLEGAL) || (nbeats_c == '0)) begin
              state         <= ST_DONE;
              bus.out_valid <= 1'b1;
              bus.out_err   <= (bus.in_mode == ALU_ILLEGAL);
            end else begin
              // Beat 0 operands are presented in the first RUN cycle.
              state            <= ST_RUN;
              bus.alu_mode     <= bus.in_mode;
              bus.alu_elen     <= bus.in_elen;
              bus.alu_op1      <= bus.in_vs1[LENGTH-1:0];
              bus.alu_op2      <= bus.in_vs2[LENGTH-1:0];
              bus.alu_carry_in <= (bus.in_mode == ALU_SUB);
            end
          end
        end
        ST_RUN: begin
          buffer_q <= merged_c;
          beat_q   <= beat_nxt_c;
          if (beat_q == last_q) begin
            state            <= ST_DONE;
            bus.out_valid    <= 1'b1;
            bus.out_data     <= merged_c;
            bus.out_byte_en  <= mask_q;
            bus.alu_mode     <= '0;
            bus.alu_elen     <= '0;
            bus.alu_op1      <= '0;
            bus.alu_op2      <= '0;
            bus.alu_carry_in <= 1'b0;
          end else begin
            bus.alu_op1 <= op1_nxt_c;
            bus.alu_op2 <= op2_nxt_c;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Scoreboard bench for vec_alu_sequencer: the bench models the external ALU,
// queues expected results at accept time and a monitor checks every result.
`timescale 1ns/1ps
module tb_vec_alu_sequencer;
  import vpu_exec_pkg::*;

  localparam int unsigned VLEN       = 256;
  localparam int unsigned LENGTH     = 32;
  localparam int unsigned SUB_LENGTH = 8;
  localparam int unsigned NBYTES     = VLEN / 8;
  localparam int unsigned BPB        = LENGTH / 8;
  localparam int unsigned VL_W       = $clog2(NBYTES) + 1;

  typedef struct {
    logic [VLEN-1:0]   data;
    logic [NBYTES-1:0] be;
    logic              err;
    int                lat;
    int                t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hs_cyc = 0;
  bit   valid_seen = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_alu_sequencer_if #(.VLEN(VLEN), .LENGTH(LENGTH)) bus ();

  vec_alu_sequencer #(.VLEN(VLEN), .LENGTH(LENGTH), .SUB_LENGTH(SUB_LENGTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] elem_op(input logic [2:0] mode, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    case (mode)
      3'd0:    return a + b;
      3'd1:    return a + ~b + 32'(cin);
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return ~a;
      3'd5:    return a ^ b;
      3'd6:    return a * b;
      default: return 32'h0;
    endcase
  endfunction

  // External combinational ALU: independent elements inside one beat.
  function automatic logic [LENGTH-1:0] alu_model(input logic [2:0] mode,
      input logic [ELEN_W-1:0] elen, input logic [LENGTH-1:0] a,
      input logic [LENGTH-1:0] b, input logic cin);
    logic [LENGTH-1:0] res;
    logic [31:0] ea, eb, r;
    int esz;
    res = '0;
    esz = (elen > 2'd2) ? 4 : (1 << elen);
    for (int e = 0; e < int'(BPB); e += esz) begin
      ea = '0;
      eb = '0;
      for (int j = 0; j < esz; j++) begin
        ea[j*8 +: 8] = a[(e+j)*8 +: 8];
        eb[j*8 +: 8] = b[(e+j)*8 +: 8];
      end
      r = elem_op(mode, ea, eb, cin);
      for (int j = 0; j < esz; j++) res[(e+j)*8 +: 8] = r[j*8 +: 8];
    end
    return res;
  endfunction

  assign bus.alu_out   = alu_model(bus.alu_mode, bus.alu_elen, bus.alu_op1, bus.alu_op2,
                                   bus.alu_carry_in);
  assign bus.alu_carry = 1'b0;

  // Whole-vector reference result for one instruction.
  function automatic exp_t model(input logic [2:0] mode, input logic [ELEN_W-1:0] elen,
      input logic [VL_W-1:0] vl, input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2);
    exp_t x;
    int esz, maxel, vle, nb;
    logic [31:0] ea, eb, r;
    esz   = 1 << elen;
    maxel = int'(NBYTES) / esz;
    vle   = (int'(vl) < maxel) ? int'(vl) : maxel;
    nb    = vle * esz;
    x.data = '0; x.be = '0; x.err = 1'b0; x.lat = 1; x.t_acc = 0;
    if (mode == 3'd7) begin
      x.err = 1'b1;
    end else begin
      for (int e = 0; e < vle; e++) begin
        ea = '0;
        eb = '0;
        for (int j = 0; j < esz; j++) begin
          ea[j*8 +: 8] = vs1[(e*esz+j)*8 +: 8];
          eb[j*8 +: 8] = vs2[(e*esz+j)*8 +: 8];
        end
        r = elem_op(mode, ea, eb, mode == 3'd1);
        for (int j = 0; j < esz; j++) x.data[(e*esz+j)*8 +: 8] = r[j*8 +: 8];
      end
      for (int k = 0; k < nb; k++) x.be[k] = 1'b1;
      if (nb > 0) x.lat = (nb + int'(BPB) - 1) / int'(BPB) + 1;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.in_ready || bus.out_valid)
          chk("alu_idle", VLEN'({bus.alu_mode, bus.alu_elen, bus.alu_op1, bus.alu_op2,
                                 bus.alu_carry_in}), '0);
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", VLEN'(bus.out_valid), '0);
          end else begin
            if (!valid_seen) begin
              chk("latency", VLEN'(cyc - sb[0].t_acc), VLEN'(sb[0].lat));
              valid_seen = 1'b1;
            end
            chk("out_data", bus.out_data, sb[0].data);
            chk("out_byte_en", VLEN'(bus.out_byte_en), VLEN'(sb[0].be));
            chk("out_err", VLEN'(bus.out_err), VLEN'(sb[0].err));
            chk("in_ready_in_done", VLEN'(bus.in_ready), '0);
            if (bus.out_ready) begin
              hs_cyc = cyc;
              void'(sb.pop_front());
              valid_seen = 1'b0;
            end
          end
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic issue_exp(input logic [2:0] mode, input logic [ELEN_W-1:0] elen,
      input logic [VL_W-1:0] vl, input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
      input exp_t x, output int t_acc);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_elen  = elen;
    bus.in_vl    = vl;
    bus.in_vs1   = vs1;
    bus.in_vs2   = vs2;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    t_acc = cyc;
    if (!bus.in_ready) begin
      chk("accept_timeout", VLEN'(bus.in_ready), VLEN'(1));
    end else begin
      x.t_acc = cyc;
      sb.push_back(x);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] mode, input logic [ELEN_W-1:0] elen,
      input logic [VL_W-1:0] vl, input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2);
    int t;
    issue_exp(mode, elen, vl, vs1, vs2, model(mode, elen, vl, vs1, vs2), t);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", VLEN'(sb.size()), '0);
  endtask

  initial begin
    logic [VLEN-1:0] pa, pb, ones, w1, w2, wexp;
    exp_t x;
    int t1, t2;

    pa   = 256'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF_0F1E2D3C_80008000_7FFF7FFF;
    pb   = 256'hFFFFFFFF_00000001_12345678_9ABCDEF0_CAFEBABE_F0E1D2C3_80018001_00010001;
    ones = {32{8'h01}};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_elen = '0; bus.in_vl = '0;
    bus.in_vs1 = '0; bus.in_vs2 = '0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_outputs", VLEN'({bus.out_valid, bus.out_err, bus.out_byte_en}), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_alu", VLEN'({bus.alu_mode, bus.alu_elen, bus.alu_op1, bus.alu_op2,
                          bus.alu_carry_in}), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));
    fork monitor(); join_none

    // ADD bytes 0xFF + 0x01 wrap to zero in every lane.
    x.data = '0; x.be = '1; x.err = 1'b0; x.lat = 9; x.t_acc = 0;
    w1 = {32{8'hFF}};
    issue_exp(3'd0, 2'd0, 6'd32, w1, ones, x, t1);

    // SUB on 32-bit words, three elements.
    w1   = {160'h0, 32'h10, 32'h0, 32'h5};
    w2   = {160'h0, 32'h10, 32'h1, 32'h3};
    wexp = {160'h0, 32'h0, 32'hFFFF_FFFF, 32'h2};
    x.data = wexp; x.be = 32'h0000_0FFF; x.err = 1'b0; x.lat = 4;
    issue_exp(3'd1, 2'd2, 6'd3, w1, w2, x, t1);

    // Zero-length and illegal-op instructions complete without beats.
    x.data = '0; x.be = '0; x.err = 1'b0; x.lat = 1;
    issue_exp(3'd0, 2'd0, 6'd0, pa, pb, x, t1);
    x.err = 1'b1;
    issue_exp(3'd7, 2'd0, 6'd5, pa, pb, x, t1);

    issue(3'd6, 2'd1, 6'd40, pa, pb);   // vl clamped to 16 halfwords
    issue(3'd2, 2'd0, 6'd7, pa, pb);    // partial final beat
    issue(3'd3, 2'd1, 6'd5, pa, pb);
    issue(3'd4, 2'd2, 6'd6, pa, pb);
    issue(3'd0, 2'd2, 6'd8, pa, pb);
    wait_drain();

    // Back-pressure: result held for 5 cycles while the next instruction waits.
    bus.out_ready = 1'b0;
    fork
      begin
        issue(3'd1, 2'd1, 6'd11, pa, pb);
        issue_exp(3'd5, 2'd0, 6'd16, pb, pa, model(3'd5, 2'd0, 6'd16, pb, pa), t2);
        chk("accept_after_handshake", VLEN'(t2), VLEN'(hs_cyc + 1));
      end
      begin
        int n = 0;
        while (!bus.out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset pulsed during beat 3 discards the instruction.
    issue_exp(3'd0, 2'd0, 6'd32, pa, pb, model(3'd0, 2'd0, 6'd32, pa, pb), t1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_outputs", VLEN'({bus.out_valid, bus.out_err, bus.out_byte_en}), '0);
    chk("midrun_rst_out_data", bus.out_data, '0);
    chk("midrun_rst_alu", VLEN'({bus.alu_mode, bus.alu_elen, bus.alu_op1, bus.alu_op2,
                                 bus.alu_carry_in}), '0);
    sb.delete();
    valid_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));
    issue(3'd0, 2'd0, 6'd32, pa, pb);
    issue(3'd1, 2'd2, 6'd8, pa, pb);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
